// File: rtl/bm_calc_out.sv
// bm_calc_out: output formatter for the block-matching pipeline.
// Applies the uniqueness reject (min1 * 1024 > uni_thr * min2), forwards
// intermediate {min,disp} records on non-final disparity phases and packs
// PACK {disp,frac} lanes per OBUF2 word on the final phase, flushing any
// partial word at end of line.
// Optional feature macro: BM_CALC_OUT_COORD_EN adds obuf2_x / obuf2_y, the
// pixel/line coordinates of lane 0 of each emitted OBUF2 word.
module bm_calc_out #(
    parameter int SAD_W  = 16,
    parameter int DISP_W = 8,
    parameter int FRAC_W = 8,
    parameter int PACK   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  last_dphase,
    input  logic                                  last_line,
    input  logic                                  uni_enb,
    input  logic                                  uni_mode,
    input  logic [9:0]                            uni_thr,
    input  logic                                  vin,
    input  logic                                  upd,
    input  logic [SAD_W-1:0]                      min1,
    input  logic [SAD_W-1:0]                      min2,
    input  logic [DISP_W-1:0]                     disp1,
    input  logic [DISP_W-1:0]                     disp2,
    input  logic [FRAC_W-1:0]                     frac,
    input  logic [FRAC_W-1:0]                     frac_upd,
    output logic                                  obuf_wr,
    output logic [2+2*(DISP_W+FRAC_W+SAD_W)-1:0]  obuf_wrdata,
    output logic                                  obuf2_wr,
    output logic [PACK*(DISP_W+FRAC_W)-1:0]       obuf2_wrdata,
    output logic [$clog2(PACK):0]                 obuf2_cnt,
    output logic                                  line_end,
    output logic [9:0]                            hcnt,
`ifdef BM_CALC_OUT_COORD_EN
    output logic [9:0]                            obuf2_x,
    output logic [8:0]                            obuf2_y,
`endif
    output logic [8:0]                            vcnt
);

    localparam int LANE_W = DISP_W + FRAC_W;
    localparam int P_W    = SAD_W + 10;
    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W  = $clog2(PACK) + 1;

    logic                  vin_s1, ld_s1, ll_s1, uni_enb_s1, uni_mode_s1, upd_s1;
    logic [SAD_W-1:0]      min1_s1, min2_s1;
    logic [DISP_W-1:0]     disp1_s1, disp2_s1;
    logic [FRAC_W-1:0]     frac_s1, frac_upd_s1;
    logic [P_W-1:0]        p1_s1, p2_s1;

    logic                  eol, act, fin_beat, nfin_beat, grp_done;
    logic [FRAC_W-1:0]     frac_sel, frac_m;
    logic [DISP_W-1:0]     disp_m;
    logic [PACK-1:0][LANE_W-1:0] acc, word_nxt;
    logic [IDX_W-1:0]      idx;
    logic                  le_ld, le_ll;
    logic [9:0]            hcnt_base;
`ifdef BM_CALC_OUT_COORD_EN
    logic [9:0]            x0;
`endif

    // S1: register every input and precompute both sides of the uniqueness compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_s1      <= 1'b0;
            ld_s1       <= 1'b0;
            ll_s1       <= 1'b0;
            uni_enb_s1  <= 1'b0;
            uni_mode_s1 <= 1'b0;
            upd_s1      <= 1'b0;
            min1_s1     <= '0;
            min2_s1     <= '0;
            disp1_s1    <= '0;
            disp2_s1    <= '0;
            frac_s1     <= '0;
            frac_upd_s1 <= '0;
            p1_s1       <= '0;
            p2_s1       <= '0;
        end else begin
            vin_s1      <= vin & ~start;
            ld_s1       <= last_dphase;
            ll_s1       <= last_line;
            uni_enb_s1  <= uni_enb;
            uni_mode_s1 <= uni_mode;
            upd_s1      <= upd;
            min1_s1     <= min1;
            min2_s1     <= min2;
            disp1_s1    <= disp1;
            disp2_s1    <= disp2;
            frac_s1     <= frac;
            frac_upd_s1 <= frac_upd;
            p1_s1       <= {min1, 10'b0};
            p2_s1       <= P_W'(uni_thr) * P_W'(min2);
        end
    end

    // S2 combinational: end-of-line detect, fraction select, reject mask, lane insert
    always_comb begin
        eol       = vin_s1 & ~vin;
        fin_beat  = vin_s1 & ld_s1;
        nfin_beat = vin_s1 & ~ld_s1;
        frac_sel  = upd_s1 ? frac_upd_s1 : frac_s1;
        act       = uni_enb_s1 & ld_s1 & (p1_s1 > p2_s1);
        disp_m    = act ? {DISP_W{uni_mode_s1}} : disp1_s1;
        frac_m    = act ? {FRAC_W{uni_mode_s1}} : frac_sel;
        grp_done  = (idx == IDX_W'(PACK - 1)) | eol;
        hcnt_base = line_end ? 10'd0 : hcnt;
        word_nxt  = acc;
        for (int k = 0; k < PACK; k++) begin
            if (IDX_W'(k) == idx)
                word_nxt[k] = {disp_m, frac_m};
        end
    end

    // S2: write strobes, packing state and pixel/line counters; start wins over beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_wr      <= 1'b0;
            obuf_wrdata  <= '0;
            obuf2_wr     <= 1'b0;
            obuf2_wrdata <= '0;
            obuf2_cnt    <= '0;
            line_end     <= 1'b0;
            le_ld        <= 1'b0;
            le_ll        <= 1'b0;
            acc          <= '0;
            idx          <= '0;
            hcnt         <= '0;
            vcnt         <= '0;
`ifdef BM_CALC_OUT_COORD_EN
            x0           <= '0;
            obuf2_x      <= '0;
            obuf2_y      <= '0;
`endif
        end else if (start) begin
            obuf_wr  <= 1'b0;
            obuf2_wr <= 1'b0;
            line_end <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            hcnt     <= '0;
            vcnt     <= '0;
`ifdef BM_CALC_OUT_COORD_EN
            x0       <= '0;
`endif
        end else begin
            obuf_wr  <= nfin_beat;
            if (nfin_beat)
                obuf_wrdata <= {ld_s1, ll_s1, disp1_s1, frac_sel, min1_s1,
                                disp2_s1, {FRAC_W{1'b0}}, min2_s1};
            line_end <= eol;
            le_ld    <= ld_s1;
            le_ll    <= ll_s1;
            obuf2_wr <= fin_beat & grp_done;
            if (fin_beat) begin
                if (grp_done) begin
                    obuf2_wrdata <= word_nxt;
                    obuf2_cnt    <= CNT_W'(idx) + CNT_W'(1);
                    acc          <= '0;
                    idx          <= '0;
`ifdef BM_CALC_OUT_COORD_EN
                    obuf2_x      <= (idx == '0) ? hcnt_base : x0;
                    obuf2_y      <= vcnt;
`endif
                end else begin
                    acc <= word_nxt;
                    idx <= idx + 1'b1;
                end
`ifdef BM_CALC_OUT_COORD_EN
                if (idx == '0)
                    x0 <= hcnt_base;
`endif
            end
            // A line's count is visible for one cycle, then clears on line_end
            if (fin_beat)
                hcnt <= hcnt_base + 10'd1;
            else if (line_end || nfin_beat)
                hcnt <= '0;
            if (line_end)
                vcnt <= (le_ld && !le_ll) ? vcnt + 9'd1 : 9'd0;
            else if (nfin_beat)
                vcnt <= '0;
        end
    end

endmodule

// File: tb/tb_bm_calc_out.sv
// Directed self-checking bench for bm_calc_out (PACK=4, 16/8/8 widths).
module tb_bm_calc_out;

    localparam int SAD_W  = 16;
    localparam int DISP_W = 8;
    localparam int FRAC_W = 8;
    localparam int PACK   = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, last_dphase, last_line, uni_enb, uni_mode, vin, upd;
    logic [9:0]  uni_thr;
    logic [15:0] min1, min2;
    logic [7:0]  disp1, disp2, frac, frac_upd;
    logic        obuf_wr, obuf2_wr, line_end;
    logic [65:0] obuf_wrdata;
    logic [63:0] obuf2_wrdata;
    logic [2:0]  obuf2_cnt;
    logic [9:0]  hcnt;
    logic [8:0]  vcnt;
`ifdef BM_CALC_OUT_COORD_EN
    logic [9:0]  obuf2_x;
    logic [8:0]  obuf2_y;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bm_calc_out #(.SAD_W(SAD_W), .DISP_W(DISP_W), .FRAC_W(FRAC_W), .PACK(PACK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_dphase(last_dphase),
        .last_line(last_line), .uni_enb(uni_enb), .uni_mode(uni_mode),
        .uni_thr(uni_thr), .vin(vin), .upd(upd), .min1(min1), .min2(min2),
        .disp1(disp1), .disp2(disp2), .frac(frac), .frac_upd(frac_upd),
        .obuf_wr(obuf_wr), .obuf_wrdata(obuf_wrdata), .obuf2_wr(obuf2_wr),
        .obuf2_wrdata(obuf2_wrdata), .obuf2_cnt(obuf2_cnt), .line_end(line_end),
        .hcnt(hcnt),
`ifdef BM_CALC_OUT_COORD_EN
        .obuf2_x(obuf2_x), .obuf2_y(obuf2_y),
`endif
        .vcnt(vcnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Single-pixel final-phase line: expect one flushed word with only lane 0 set
    task automatic one_pix(input string tag, input logic [15:0] m1, input logic [15:0] m2,
                           input logic [7:0] d, input logic [7:0] f, input logic [7:0] fu,
                           input logic [15:0] exp_lane);
        min1 = m1; min2 = m2; disp1 = d; frac = f; frac_upd = fu;
        vin = 1'b1;
        tick();
        vin = 1'b0;
        tick();
        chk({tag, "_wr"},   obuf2_wr, 1);
        chk({tag, "_cnt"},  obuf2_cnt, 1);
        chk({tag, "_data"}, obuf2_wrdata, {48'h0, exp_lane});
        tick();
    endtask

    initial begin
        logic [65:0] exp_rec;
        int          j;
        rst_n = 1'b0; start = 1'b0; last_dphase = 1'b0; last_line = 1'b0;
        uni_enb = 1'b0; uni_mode = 1'b0; uni_thr = '0; vin = 1'b0; upd = 1'b0;
        min1 = '0; min2 = '0; disp1 = '0; disp2 = '0; frac = '0; frac_upd = '0;
        tick();
        tick();

        chk("rst_obuf_wr",      obuf_wr, 0);
        chk("rst_obuf_wrdata",  obuf_wrdata, 0);
        chk("rst_obuf2_wr",     obuf2_wr, 0);
        chk("rst_obuf2_wrdata", obuf2_wrdata, 0);
        chk("rst_obuf2_cnt",    obuf2_cnt, 0);
        chk("rst_line_end",     line_end, 0);
        chk("rst_hcnt",         hcnt, 0);
        chk("rst_vcnt",         vcnt, 0);
`ifdef BM_CALC_OUT_COORD_EN
        chk("rst_x", obuf2_x, 0);
        chk("rst_y", obuf2_y, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Uniqueness: 100*1024 == 512*200 keeps, 101*1024 > 512*200 rejects
        last_dphase = 1'b1; uni_enb = 1'b1; uni_thr = 10'd512; uni_mode = 1'b0;
        one_pix("uni_eq_m0", 16'd100, 16'd200, 8'h05, 8'h33, 8'h00, 16'h0533);
        one_pix("uni_gt_m0", 16'd101, 16'd200, 8'h05, 8'h33, 8'h00, 16'h0000);
        uni_mode = 1'b1;
        one_pix("uni_gt_m1", 16'd101, 16'd200, 8'h05, 8'h33, 8'h00, 16'hFFFF);
        one_pix("uni_eq_m1", 16'd100, 16'd200, 8'h05, 8'h33, 8'h00, 16'h0533);
        uni_enb = 1'b0;
        one_pix("uni_off",   16'd101, 16'd200, 8'h05, 8'h33, 8'h00, 16'h0533);

        // Fraction select
        upd = 1'b1;
        one_pix("frac_upd", 16'd10, 16'd20, 8'h07, 8'h11, 8'h22, 16'h0722);
        upd = 1'b0;
        one_pix("frac_old", 16'd10, 16'd20, 8'h07, 8'h11, 8'h22, 16'h0711);

        // Packing with flush: 10 beats, disp=1..10, frac=0xA0+disp
        pulse_start();
        min1 = '0; min2 = '0;
        for (int i = 1; i <= 12; i++) begin
            vin   = (i <= 10);
            disp1 = 8'(i);
            frac  = 8'(8'hA0 + i);
            tick();
            chk("pk_obuf2_wr", obuf2_wr, (i == 5 || i == 9 || i == 11));
            chk("pk_line_end", line_end, (i == 11));
            chk("pk_obuf_wr",  obuf_wr, 0);
            if (i == 5) begin
                chk("pk_w0_data", obuf2_wrdata, 64'h04A4_03A3_02A2_01A1);
                chk("pk_w0_cnt",  obuf2_cnt, 4);
`ifdef BM_CALC_OUT_COORD_EN
                chk("pk_w0_x", obuf2_x, 0);
                chk("pk_w0_y", obuf2_y, 0);
`endif
            end
            if (i == 9) begin
                chk("pk_w1_data", obuf2_wrdata, 64'h08A8_07A7_06A6_05A5);
                chk("pk_w1_cnt",  obuf2_cnt, 4);
`ifdef BM_CALC_OUT_COORD_EN
                chk("pk_w1_x", obuf2_x, 4);
`endif
            end
            if (i == 11) begin
                chk("pk_flush_data", obuf2_wrdata, 64'h0000_0000_0AAA_09A9);
                chk("pk_flush_cnt",  obuf2_cnt, 2);
                chk("pk_hcnt_full",  hcnt, 10);
`ifdef BM_CALC_OUT_COORD_EN
                chk("pk_flush_x", obuf2_x, 8);
`endif
            end
            if (i == 12) begin
                chk("pk_hcnt_clr", hcnt, 0);
                chk("pk_vcnt",     vcnt, 1);
            end
        end

        // Non-final phase: three records, no packed writes
        pulse_start();
        last_dphase = 1'b0; last_line = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            vin   = (i <= 3);
            disp1 = 8'(i);
            disp2 = 8'(8'h40 + i);
            min1  = 16'(16'h0100 + i);
            min2  = 16'(16'h0200 + i);
            frac  = 8'(8'h50 + i);
            tick();
            chk("nf_obuf_wr",  obuf_wr, (i >= 2 && i <= 4));
            chk("nf_obuf2_wr", obuf2_wr, 0);
            chk("nf_line_end", line_end, (i == 4));
            if (i >= 2 && i <= 4) begin
                j = i - 1;
                exp_rec = {1'b0, 1'b1, 8'(j), 8'(8'h50 + j), 16'(16'h0100 + j),
                           8'(8'h40 + j), 8'h00, 16'(16'h0200 + j)};
                chk("nf_record", obuf_wrdata, exp_rec);
            end
        end
        chk("nf_hcnt", hcnt, 0);

        // Frame wrap: 3 two-pixel lines, last_line on the third
        pulse_start();
        last_dphase = 1'b1;
        for (int ln = 0; ln < 3; ln++) begin
            last_line = (ln == 2);
            vin = 1'b1;
            tick();
            tick();
            vin = 1'b0;
            tick();
            chk("fw_line_end", line_end, 1);
            chk("fw_cnt",      obuf2_cnt, 2);
            tick();
            chk("fw_vcnt", vcnt, (ln == 0) ? 1 : (ln == 1) ? 2 : 0);
        end

        // start mid-group drops the in-flight beats
        last_line = 1'b0; frac = 8'h00;
        pulse_start();
        vin = 1'b1; disp1 = 8'h31;
        tick();
        disp1 = 8'h32;
        tick();
        vin = 1'b0; start = 1'b1;
        tick();
        chk("st_obuf2_wr_a", obuf2_wr, 0);
        chk("st_line_end",   line_end, 0);
        chk("st_hcnt",       hcnt, 0);
        start = 1'b0;
        tick();
        chk("st_obuf2_wr_b", obuf2_wr, 0);
        for (int i = 1; i <= 6; i++) begin
            vin   = (i <= 4);
            disp1 = 8'(8'h40 + i);
            tick();
            chk("st_obuf2_wr", obuf2_wr, (i == 5));
            if (i == 5) begin
                chk("st_data", obuf2_wrdata, 64'h4400_4300_4200_4100);
                chk("st_cnt",  obuf2_cnt, 4);
`ifdef BM_CALC_OUT_COORD_EN
                chk("st_x", obuf2_x, 0);
`endif
            end
        end

        // Reset mid-line discards the partial group
        vin = 1'b1; disp1 = 8'h55;
        tick();
        disp1 = 8'h56;
        tick();
        rst_n = 1'b0; vin = 1'b0;
        #1;
        chk("mr_obuf2_wr", obuf2_wr, 0);
        chk("mr_hcnt",     hcnt, 0);
        tick();
        chk("mr_obuf2_wr_hold", obuf2_wr, 0);
        rst_n = 1'b1;
        tick();
        last_dphase = 1'b1;
        one_pix("post_rst", 16'd1, 16'd1, 8'h05, 8'h33, 8'h00, 16'h0533);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
